// File: rtl/synth_pkg.sv
// Shared definitions for the voice oscillator slice: default geometry,
// scan controller states and the frequency word type.
package synth_pkg;

    localparam int DEFAULT_VOICES  = 8;
    localparam int DEFAULT_FREQ_W  = 20;
    localparam int DEFAULT_PHASE_W = 24;
    localparam int SEL_W           = 3;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        OUT
    } scan_state_t;

    typedef logic [DEFAULT_FREQ_W-1:0] freq_t;

endpackage

// File: rtl/voice_scan_nco_if.sv
// Bundles the sample strobe, loader write handshake, shared RAM port and
// mix outputs of the voice scanner into one connection.
interface voice_scan_nco_if
    import synth_pkg::*;
#(
    parameter int VOICES = DEFAULT_VOICES,
    parameter int FREQ_W = DEFAULT_FREQ_W
);

    logic              sample_en;
    logic              wr_req;
    logic [SEL_W-1:0]  wr_sel;
    logic [FREQ_W-1:0] wr_data;
    logic              wr_ack;
    logic [SEL_W-1:0]  ram_sel;
    logic              ram_load;
    logic [FREQ_W-1:0] ram_in;
    logic [FREQ_W-1:0] ram_out;
    logic [VOICES-1:0] square;
    logic [3:0]        mix;
    logic              sample_valid;
    logic              busy;
    logic              overrun;

    // The environment side: strobe source, note loader and frequency RAM.
    modport master (
        output sample_en, wr_req, wr_sel, wr_data, ram_out,
        input  wr_ack, ram_sel, ram_load, ram_in,
               square, mix, sample_valid, busy, overrun
    );

    modport slave (
        input  sample_en, wr_req, wr_sel, wr_data, ram_out,
        output wr_ack, ram_sel, ram_load, ram_in,
               square, mix, sample_valid, busy, overrun
    );

endinterface

// File: rtl/voice_scan_nco_phase_bank.sv
// Per-voice phase accumulators with one read-modify-write port and a
// parallel view of every accumulator's MSB.
module phase_bank #(
    parameter int VOICES  = 8,
    parameter int FREQ_W  = 20,
    parameter int PHASE_W = 24,
    parameter int IDX_W   = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IDX_W-1:0]  idx,
    input  logic [FREQ_W-1:0] inc,
    input  logic              en,
    output logic [VOICES-1:0] msb
);

    logic [PHASE_W-1:0] phase [VOICES];

    // NOTE: this array is reset on purpose -- phases must restart from zero
    // after rst_n, which keeps it out of RAM macros and in flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < VOICES; i++) begin
                phase[i] <= '0;
            end
        end else if (en) begin
            phase[idx] <= phase[idx] + PHASE_W'(inc);
        end
    end

    always_comb begin
        for (int i = 0; i < VOICES; i++) begin
            msb[i] = phase[i][PHASE_W-1];
        end
    end

endmodule

// File: rtl/voice_scan_nco.sv
// Sample-strobed voice scanner: walks the frequency RAM once per sample,
// advances each voice's phase and publishes a square-wave mix.
module voice_scan_nco
    import synth_pkg::*;
#(
    parameter int VOICES  = DEFAULT_VOICES,
    parameter int FREQ_W  = DEFAULT_FREQ_W,
    parameter int PHASE_W = DEFAULT_PHASE_W
) (
    input  logic            clk,
    input  logic            rst_n,
    voice_scan_nco_if.slave bus
);

    scan_state_t       state;
    logic [SEL_W-1:0]  idx;
    logic              pending;
    logic [VOICES-1:0] active;
    logic [VOICES-1:0] msb;
    logic [VOICES-1:0] square_next;
    logic [3:0]        mix_next;
    logic [VOICES-1:0] square_q;
    logic [3:0]        mix_q;
    logic              valid_q;
    logic              overrun_q;
    logic              grant;

    // Loader writes only get the RAM port while the scanner is parked.
    assign grant        = rst_n && (state == IDLE) && bus.wr_req;
    assign bus.wr_ack   = grant;
    assign bus.ram_load = grant;
    assign bus.ram_sel  = grant ? bus.wr_sel : ((state == SCAN) ? idx : '0);
    assign bus.ram_in   = bus.wr_data;
    assign bus.busy     = (state != IDLE);

    assign bus.square       = square_q;
    assign bus.mix          = mix_q;
    assign bus.sample_valid = valid_q;
    assign bus.overrun      = overrun_q;

    phase_bank #(
        .VOICES (VOICES),
        .FREQ_W (FREQ_W),
        .PHASE_W(PHASE_W),
        .IDX_W  (SEL_W)
    ) u_bank (
        .clk  (clk),
        .rst_n(rst_n),
        .idx  (idx),
        .inc  (bus.ram_out),
        .en   (state == SCAN),
        .msb  (msb)
    );

    // NOTE: every variable gets a value before the loop so no latch is inferred.
    always_comb begin
        square_next = msb & active;
        mix_next    = '0;
        for (int i = 0; i < VOICES; i++) begin
            mix_next = mix_next + 4'(square_next[i]);
        end
    end

    // NOTE: non-blocking assignments throughout so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            pending   <= 1'b0;
            active    <= '0;
            square_q  <= '0;
            mix_q     <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.wr_req) begin
                        if (bus.sample_en) pending <= 1'b1;
                    end else if (bus.sample_en || pending) begin
                        pending <= 1'b0;
                        idx     <= '0;
                        state   <= SCAN;
                    end
                end
                SCAN: begin
                    active[idx] <= (bus.ram_out != '0);
                    idx         <= idx + 1'b1;
                    if (idx == SEL_W'(VOICES - 1)) state <= OUT;
                end
                OUT: begin
                    square_q <= square_next;
                    mix_q    <= mix_next;
                    valid_q  <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
            // One strobe may queue behind a running scan; a second is dropped.
            if (state != IDLE && bus.sample_en) begin
                if (!pending) pending   <= 1'b1;
                else          overrun_q <= 1'b1;
            end
        end
    end

endmodule
